mp3_sdi_rx: RTL
===============

MP3_SDI_RX -- requirements
Module: mp3_sdi_rx

Interface
REQ-001 The block SHALL have these ports, one clock domain; sck, sdi and bsync are asynchronous to clk:
- clk  input  1  system clock (clk_fpga); all logic rising-edge.
- rst  input  1  reset; synchronous, active-high.
- sck  input  1  serial data clock from the spi2-style data transmitter.
- sdi  input  1  serial data, MSB first, sampled on sck rising edge.
- bsync  input  1  byte sync, high during the MSB bit of each byte.
- req  output  1  flow control to the transmitter (DREQ): 1 = may send.
- rd_data  output  8  FIFO head byte, show-ahead.
- rd_valid  output  1  FIFO not empty.
- rd_ack  input  1  pop head; ignored when rd_valid=0.
- level  output  5  FIFO occupancy, 0..16.
- overrun  output  1  sticky: a byte was dropped on a full FIFO.
- framing_err  output  1  sticky: bsync seen mid-byte.
- err_clr  input  1  clears both sticky flags.

Function
REQ-002 sck, sdi and bsync SHALL each pass through a 2-flop synchronizer; an sck rising edge is detected from synchronized samples; sck high and low phases are each >=2 clk periods.
REQ-003 Receive FSM states SHALL be HUNT and SHIFT; it resets to HUNT.
REQ-004 In HUNT, sck edges with bsync=0 SHALL be ignored; an edge with bsync=1 loads shift={7'b0,sdi}, bitcnt=1, and enters SHIFT.
REQ-005 In SHIFT, an edge with bsync=0 SHALL shift sdi in at the LSB and increment bitcnt; when bitcnt reaches 8, the byte is pushed and the FSM goes to HUNT.
REQ-006 In SHIFT, an edge with bsync=1 and bitcnt in 1..7 SHALL discard the partial byte, set framing_err, and restart as in REQ-004.
REQ-007 Push latency SHALL be fixed: rd_valid rises exactly 4 clk after the clk edge that first registers the 8th sck high at the pin-side synchronizer input (2 sync + 1 edge detect + 1 push).
REQ-008 The FIFO SHALL be 16 entries, 4-bit wrapping pointers, with level computed as a 5-bit count.
REQ-009 A push with level=16 and no same-cycle pop SHALL drop the byte and set overrun; FIFO contents are unchanged.
REQ-010 A simultaneous push and pop SHALL both succeed at any level, including 16 and 0 with rd_valid=0 (pop ignored, push accepted), leaving level unchanged, or +1 when empty.
REQ-011 rd_ack with rd_valid=1 SHALL advance the head on that clk edge; rd_data shows the next byte on the following cycle.
REQ-012 req SHALL be registered: 1 when level<=12, 0 when level>=13, updated one clk after level changes.
REQ-013 err_clr SHALL clear overrun and framing_err; a same-cycle set event wins over the clear.

Reset
REQ-014 While rst=1 on a clk edge, the block SHALL set FSM=HUNT, bitcnt=0, shift=0, FIFO pointers=0, level=0, rd_valid=0, rd_data=0, overrun=0, framing_err=0, req=0, and synchronizer flops=0.
REQ-015 A reset mid-byte SHALL discard the partial byte and all queued data; after release, reception starts only at the next bsync=1 edge, and req returns to 1 one clk after release.

Structure
REQ-016 FIFO_DEPTH=16, REQ_THRESHOLD=12 and the FSM state encoding SHALL live in the shared package neogs_mp3_pkg.
REQ-017 Storage SHALL be one sub-module, rx_fifo (synchronous 16x8, show-ahead, push/pop/level/full/empty); the synchronizer, edge detector and FSM stay in mp3_sdi_rx.

Verification
REQ-018 Send bytes 0xA5 then 0x3C, each with bsync on the MSB, sck=clk/8 -> rd_data=0xA5 then 0x3C, rd_valid 4 clk after each 8th edge, framing_err=0.
REQ-019 Send 5 sck edges with bsync=0 after reset, then 0x81 framed -> only 0x81 queued, level=1.
REQ-020 Send 0xFF truncated after 4 bits by a new bsync starting 0x12 -> only 0x12 queued, framing_err=1; err_clr -> 0.
REQ-021 Send 17 bytes 0x00..0x10 without popping -> req falls when level reaches 13, level=16, overrun=1, bytes 0x00..0x0F read back in order.
REQ-022 At level=16, pop on the exact cycle of a push -> level stays 16, overrun=0, new byte is last.
REQ-023 Assert rst after 3 bits of a byte with level=5 -> level=0, rd_valid=0, req=1 one clk after release, next framed byte is received correctly.

Source files
------------

// File: rtl/neogs_mp3_pkg.sv
// Shared constants and state encoding for the MP3 serial data receiver.
// Holds the FIFO geometry, the DREQ threshold and the receive FSM states.
package neogs_mp3_pkg;

    localparam int FIFO_DEPTH    = 16;
    localparam int PTR_W         = 4;
    localparam int LVL_W         = 5;
    localparam int REQ_THRESHOLD = 12;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    // Transmitter may keep sending while the FIFO has room for a full burst.
    function automatic logic req_from_level(input logic [LVL_W-1:0] lvl);
        return (lvl <= LVL_W'(REQ_THRESHOLD));
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// 16x8 synchronous show-ahead FIFO with occupancy count.
// A pop and a push in the same cycle both succeed, even when full.
module rx_fifo
    import neogs_mp3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    output logic [7:0]       rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LVL_W'(FIFO_DEPTH));
    assign level_o = count_q;

    // Show-ahead head; forced to zero while empty so stale RAM never leaks out.
    assign rd_data_o = empty_o ? 8'h00 : mem[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mp3_sdi_rx.sv
// Serial MP3 data receiver: synchronizes sck/sdi/bsync, assembles bytes
// framed by bsync, queues them in rx_fifo and drives DREQ flow control.
module mp3_sdi_rx
    import neogs_mp3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             sdi,
    input  logic             bsync,
    output logic             req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic [LVL_W-1:0] level,
    output logic             overrun,
    output logic             framing_err,
    input  logic             err_clr
);

    logic [2:0] pin_in;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       sck_prev_q;
    logic       rise_q;
    logic       sdi_dly_q;
    logic       bsync_dly_q;

    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       push_q, push_d;
    logic [7:0] push_data_q, push_data_d;
    logic       frame_set;

    logic       overrun_q, overrun_d;
    logic       framing_q, framing_d;
    logic       req_q;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overrun_set;

    assign pin_in = {bsync, sdi, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                end else begin
                    sync1_q[gi] <= pin_in[gi];
                    sync2_q[gi] <= sync1_q[gi];
                end
            end
        end
    endgenerate

    // Edge detect stage also delays sdi/bsync so they stay aligned with rise_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            sdi_dly_q   <= 1'b0;
            bsync_dly_q <= 1'b0;
        end else begin
            sck_prev_q  <= sync2_q[0];
            rise_q      <= sync2_q[0] & ~sck_prev_q;
            sdi_dly_q   <= sync2_q[1];
            bsync_dly_q <= sync2_q[2];
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        frame_set   = 1'b0;
        if (rise_q) begin
            if (bsync_dly_q) begin
                frame_set = (state_q == ST_SHIFT);
                shift_d   = {7'b0, sdi_dly_q};
                bitcnt_d  = 4'd1;
                state_d   = ST_SHIFT;
            end else if (state_q == ST_SHIFT) begin
                shift_d = {shift_q[6:0], sdi_dly_q};
                if (bitcnt_q == 4'd7) begin
                    push_d      = 1'b1;
                    push_data_d = {shift_q[6:0], sdi_dly_q};
                    bitcnt_d    = 4'd0;
                    state_d     = ST_HUNT;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    rx_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (rd_ack),
        .rd_data_o   (rd_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (level)
    );

    assign rd_valid = ~fifo_empty;

    // Set events take priority over a same-cycle clear.
    always_comb begin
        overrun_set = push_q & fifo_full & ~(rd_ack & rd_valid);
        overrun_d   = overrun_set | (overrun_q & ~err_clr);
        framing_d   = frame_set | (framing_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            framing_q <= framing_d;
            req_q     <= req_from_level(level);
        end
    end

    assign overrun     = overrun_q;
    assign framing_err = framing_q;
    assign req         = req_q;

endmodule
